// File: rtl/hex_count_display_if.sv
// rtl/hex_count_display_if.sv - control and display bus of the hex counter
interface hex_count_display_if #(
  parameter int DIGITS = 2
);
  localparam int W = 4 * DIGITS;

  logic               start;
  logic               stop;
  logic               clear;
  logic               load;
  logic [W-1:0]       load_val;
  logic               down;
  logic [W-1:0]       count;
  logic               wrap;
  logic               running;
  logic [9*DIGITS-1:0] seg_led;

  modport master (
    output start, stop, clear, load, load_val, down,
    input  count, wrap, running, seg_led
  );

  modport slave (
    input  start, stop, clear, load, load_val, down,
    output count, wrap, running, seg_led
  );
endinterface

// File: rtl/hex_count_display.sv
// rtl/hex_count_display.sv - prescaled hex up/down counter with registered seven-segment outputs
// Optional HEX_COUNT_LZ_BLANK_EN: blank leading-zero digits above digit 0.
module hex_count_display #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 12000000,
  parameter int PS_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  hex_count_display_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t              state_q, state_d;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic [W-1:0]        count_q, count_d;
  logic                wrap_q, wrap_d;
  logic                tick;
  logic [9*DIGITS-1:0] seg_q, seg_d;
`ifdef HEX_COUNT_LZ_BLANK_EN
  logic                upper_zero;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3f;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5b;
      4'h3: hex7 = 7'h4f;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6d;
      4'h6: hex7 = 7'h7d;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7f;
      4'h9: hex7 = 7'h6f;
      4'ha: hex7 = 7'h77;
      4'hb: hex7 = 7'h7c;
      4'hc: hex7 = 7'h39;
      4'hd: hex7 = 7'h5e;
      4'he: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // stop outranks start, so a simultaneous pair never leaves IDLE/HOLD
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start && !bus.stop) state_d = RUN;
        RUN:     if (bus.stop) state_d = HOLD;
        HOLD:    if (bus.start && !bus.stop) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  assign tick = (state_q == RUN) && (ps_q == PS_LAST);

  always_comb begin
    ps_d    = ps_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      ps_d    = '0;
      count_d = '0;
    end else if (bus.load) begin
      ps_d    = '0;
      count_d = bus.load_val;
    end else begin
      if (state_q == RUN) begin
        ps_d = tick ? '0 : ps_q + PS_W'(1);
      end else if (state_q == IDLE) begin
        ps_d = '0;
      end
      if (tick) begin
        if (bus.down) begin
          count_d = count_q - W'(1);
          wrap_d  = (count_q == '0);
        end else begin
          count_d = count_q + W'(1);
          wrap_d  = (count_q == '1);
        end
      end
    end
  end

  // Decoded from the current registers, so seg_led trails count/state by one cycle
  always_comb begin
    seg_d = '0;
`ifdef HEX_COUNT_LZ_BLANK_EN
    upper_zero = 1'b1;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seg_d[9*k +: 9] = {2'b00, hex7(count_q[4*k +: 4])};
`ifdef HEX_COUNT_LZ_BLANK_EN
      upper_zero = upper_zero && (count_q[4*k +: 4] == 4'h0);
      if (k != 0 && upper_zero) seg_d[9*k +: 9] = '0;
`endif
    end
    seg_d[7] = (state_q == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ps_q    <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      seg_q   <= {DIGITS{9'h03f}};
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.running = (state_q == RUN);
  assign bus.seg_led = seg_q;
endmodule
